// File: rtl/bus_xfer_pkg.sv
// Shared constants for the bus transfer master: state encoding and defaults.
// Also provides a width helper for the turnaround counter.
package bus_xfer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_REQ  = 3'd1;
  localparam state_t S_XFER = 3'd2;
  localparam state_t S_CMPL = 3'd3;
  localparam state_t S_TURN = 3'd4;

  localparam int LEN_W_DEF    = 4;
  localparam int TURN_CYC_DEF = 2;
  localparam int TO_CYC_DEF   = 16;

  function automatic int turn_cnt_w(input int turn_cyc);
    if (turn_cyc < 2) return 1;
    return $clog2(turn_cyc + 1);
  endfunction

endpackage

// File: rtl/bus_xfer_master_if.sv
// Command, arbiter and beat signals of the bus transfer master.
// err exists only when BUS_XFER_MASTER_WDOG_EN is defined.
interface bus_xfer_master_if #(
  parameter int LEN_W = bus_xfer_pkg::LEN_W_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             req;
  logic             gnt;
  logic             beat_valid;
  logic             tgt_rdy;
  logic [LEN_W-1:0] beat_idx;
  logic             done;
  logic             dly;
  logic             busy;
`ifdef BUS_XFER_MASTER_WDOG_EN
  logic             err;

  modport master (
    input  cmd_valid, cmd_len, gnt, tgt_rdy,
    output cmd_ready, req, beat_valid, beat_idx,
    output done, dly, busy, err
  );

  modport slave (
    output cmd_valid, cmd_len, gnt, tgt_rdy,
    input  cmd_ready, req, beat_valid, beat_idx,
    input  done, dly, busy, err
  );
`else
  modport master (
    input  cmd_valid, cmd_len, gnt, tgt_rdy,
    output cmd_ready, req, beat_valid, beat_idx,
    output done, dly, busy
  );

  modport slave (
    output cmd_valid, cmd_len, gnt, tgt_rdy,
    input  cmd_ready, req, beat_valid, beat_idx,
    input  done, dly, busy
  );
`endif

endinterface

// File: rtl/bus_turn_timer.sv
// Loadable down-counter: dly_o is high while the count is nonzero.
// last_o flags the final turnaround cycle so the owner can leave its wait state.
module bus_turn_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             dly_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dly_o  = cnt_q != '0;
  assign last_o = cnt_q == CNT_W'(1);

endmodule

// File: rtl/bus_xfer_master.sv
// Requester stage feeding the bus arbiter: req, beats, done and turnaround dly.
// BUS_XFER_MASTER_WDOG_EN adds a stall watchdog with an err output.
module bus_xfer_master
  import bus_xfer_pkg::*;
#(
  parameter int LEN_W    = LEN_W_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF,
  parameter int TO_CYC   = TO_CYC_DEF
) (
  input logic               clk,
  input logic               rst_n,
  bus_xfer_master_if.master bus
);

  localparam int TW = turn_cnt_w(TURN_CYC);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] idx_q, idx_d;

  logic in_xfer;
  logic beat_acc;
  logic last_beat;
  logic abort;
  logic turn_load;
  logic turn_dly;
  logic turn_last;

  assign in_xfer   = state_q == S_XFER;
  assign beat_acc  = in_xfer & bus.gnt & bus.tgt_rdy;
  assign last_beat = beat_acc & (idx_q == rem_q);

`ifdef BUS_XFER_MASTER_WDOG_EN
  localparam int SW = $clog2(TO_CYC + 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
  logic          stall;

  assign stall = in_xfer & bus.gnt & ~bus.tgt_rdy;
  assign abort = stall & (stall_q == SW'(TO_CYC - 1));

  always_comb begin
    stall_d = stall_q;
    if (!in_xfer || beat_acc || abort) begin
      stall_d = '0;
    end else if (stall) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && bus.cmd_valid) begin
      err_d = 1'b0;
    end else if (abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_to;

  assign abort     = 1'b0;
  assign unused_to = TO_CYC != 0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    turn_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rem_d   = bus.cmd_len;
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.gnt) state_d = S_XFER;
      end
      S_XFER: begin
        // index is cleared rather than bumped on the last beat so it never wraps
        if (last_beat || abort) begin
          state_d   = S_CMPL;
          idx_d     = '0;
          turn_load = 1'b1;
        end else if (beat_acc) begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_CMPL: begin
        state_d = (TURN_CYC > 1) ? S_TURN : S_IDLE;
      end
      S_TURN: begin
        if (turn_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  // loaded on the edge into CMPL so dly rises together with done
  bus_turn_timer #(
    .CNT_W(TW)
  ) u_turn (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (turn_load),
    .load_val_i(TW'(TURN_CYC)),
    .dly_o     (turn_dly),
    .last_o    (turn_last)
  );

  assign bus.cmd_ready  = state_q == S_IDLE;
  assign bus.req        = (state_q == S_REQ) | in_xfer;
  assign bus.beat_valid = in_xfer & bus.gnt;
  assign bus.beat_idx   = idx_q;
  assign bus.done       = state_q == S_CMPL;
  assign bus.dly        = turn_dly;
  assign bus.busy       = state_q != S_IDLE;

endmodule

// File: tb/tb_bus_xfer_master.sv
// Self-checking bench: two masters (turnaround 2 and 0) against a cycle model.
// Directed bursts plus literal expectations on beat counts and latencies.
module tb_bus_xfer_master;

  localparam int LW  = 4;
  localparam int TC0 = 2;
  localparam int TC1 = 0;
  localparam int TO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  bus_xfer_master_if #(.LEN_W(LW)) bi0 ();
  bus_xfer_master_if #(.LEN_W(LW)) bi1 ();

  bus_xfer_master #(
    .LEN_W(LW), .TURN_CYC(TC0), .TO_CYC(TO)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bi0)
  );

  bus_xfer_master #(
    .LEN_W(LW), .TURN_CYC(TC1), .TO_CYC(TO)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bi1)
  );

  logic          cv[2];
  logic [LW-1:0] cl[2];
  logic          gn[2];
  logic          tr[2];
  logic          crdy[2], rq[2], bv[2];
  logic          dn[2], dl[2], bs[2];
  logic [LW-1:0] ix[2];

  assign bi0.cmd_valid = cv[0];
  assign bi0.cmd_len   = cl[0];
  assign bi0.gnt       = gn[0];
  assign bi0.tgt_rdy   = tr[0];
  assign bi1.cmd_valid = cv[1];
  assign bi1.cmd_len   = cl[1];
  assign bi1.gnt       = gn[1];
  assign bi1.tgt_rdy   = tr[1];

  assign crdy[0] = bi0.cmd_ready;
  assign rq[0]   = bi0.req;
  assign bv[0]   = bi0.beat_valid;
  assign ix[0]   = bi0.beat_idx;
  assign dn[0]   = bi0.done;
  assign dl[0]   = bi0.dly;
  assign bs[0]   = bi0.busy;
  assign crdy[1] = bi1.cmd_ready;
  assign rq[1]   = bi1.req;
  assign bv[1]   = bi1.beat_valid;
  assign ix[1]   = bi1.beat_idx;
  assign dn[1]   = bi1.done;
  assign dl[1]   = bi1.dly;
  assign bs[1]   = bi1.busy;

`ifdef BUS_XFER_MASTER_WDOG_EN
  logic er[2];
  assign er[0] = bi0.err;
  assign er[1] = bi1.err;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int u,
                     input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s unit%0d actual=%0h required=%0h", nm, u, a, e);
    end
  endtask

  function automatic int turn_of(input int u);
    return (u == 0) ? TC0 : TC1;
  endfunction

  function automatic int tail_of(input int u);
    return (turn_of(u) > 0) ? turn_of(u) : 1;
  endfunction

  // arbiter stand-in: grant follows the previous cycle's request
  bit req_p[2];
  bit gdrop[2];

  initial begin
    gn[0] = 1'b0;
    gn[1] = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      for (int u = 0; u < 2; u++) gn[u] = req_p[u] & ~gdrop[u];
    end
  end

  // model: burst in flight, grant seen, beats wanted/accepted, tail left
  bit m_act[2], m_gr[2], m_err[2];
  int m_n[2], m_got[2], m_tl[2], m_st[2];

  // monitor on unit mu
  int mu;
  int cyc;
  int acc_cnt, bv_cnt, hold1_cnt, done_cnt, dly_cnt;
  int idx_last, idx_max, acc_cyc, done_cyc;
  int last_cyc, rise_cyc, first_bv;
  bit req_was, err_done;

  task automatic clr(input int u);
    mu = u;
    acc_cnt = 0; bv_cnt = 0; hold1_cnt = 0;
    done_cnt = 0; dly_cnt = 0;
    idx_last = -1; idx_max = -1; acc_cyc = -1;
    done_cyc = -1; last_cyc = -1; rise_cyc = -1;
    first_bv = -1; err_done = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      bit e_busy;
      int pos;
      req_p[u] = rq[u];
      if (!rst_n) begin
        m_act[u] = 0; m_gr[u] = 0; m_err[u] = 0;
        m_n[u] = 0; m_got[u] = 0; m_tl[u] = 0; m_st[u] = 0;
      end else begin
        e_busy = m_act[u] || (m_tl[u] > 0);
        pos    = tail_of(u) - m_tl[u];
        chk("cmd_ready", u, crdy[u], !e_busy);
        chk("busy", u, bs[u], e_busy);
        chk("req", u, rq[u], m_act[u]);
        chk("beat_valid", u, bv[u], m_act[u] && m_gr[u] && gn[u]);
        chk("beat_idx", u, ix[u], m_act[u] ? m_got[u] : 0);
        chk("done", u, dn[u], (m_tl[u] > 0) && (pos == 0));
        chk("dly", u, dl[u], (m_tl[u] > 0) && (pos < turn_of(u)));
`ifdef BUS_XFER_MASTER_WDOG_EN
        chk("err", u, er[u], m_err[u]);
`endif
        if (u == mu) begin
          if (cv[u] && crdy[u]) acc_cyc = cyc;
          if (rq[u] && !req_was) rise_cyc = cyc;
          req_was = rq[u];
          if (bv[u]) begin
            bv_cnt++;
            if (first_bv < 0) first_bv = cyc;
            if (ix[u] == 1) hold1_cnt++;
          end
          if (bv[u] && tr[u]) begin
            acc_cnt++;
            idx_last = ix[u];
            if (idx_last > idx_max) idx_max = idx_last;
            last_cyc = cyc;
          end
          if (dn[u]) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef BUS_XFER_MASTER_WDOG_EN
            err_done = er[u];
`endif
          end
          if (dl[u]) dly_cnt++;
        end
        if (m_tl[u] > 0) m_tl[u]--;
        if (!e_busy) begin
          if (cv[u]) begin
            m_act[u] = 1; m_gr[u] = 0; m_err[u] = 0;
            m_n[u] = int'(cl[u]) + 1; m_got[u] = 0; m_st[u] = 0;
          end
        end else if (m_act[u]) begin
          if (!m_gr[u]) begin
            if (gn[u]) m_gr[u] = 1;
          end else if (gn[u]) begin
            if (tr[u]) begin
              m_got[u]++;
              m_st[u] = 0;
              if (m_got[u] == m_n[u]) begin
                m_act[u] = 0;
                m_tl[u]  = tail_of(u);
              end
            end
`ifdef BUS_XFER_MASTER_WDOG_EN
            else begin
              m_st[u]++;
              if (m_st[u] == TO) begin
                m_act[u] = 0;
                m_tl[u]  = tail_of(u);
                m_err[u] = 1;
              end
            end
`endif
          end
        end
      end
    end
  end

  task automatic send(input int u, input int len);
    int n = 0;
    @(negedge clk);
    while (!crdy[u] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("ready_timeout", u, 0, 1);
    @(posedge clk);
    #1;
    cv[u] = 1'b1;
    cl[u] = len[LW-1:0];
    @(posedge clk);
    #1;
    cv[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    @(negedge clk);
    while (bs[u] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("idle_timeout", u, 0, 1);
    #1;
  endtask

  task automatic wait_beat(input int u, input int k);
    int n = 0;
    @(negedge clk);
    while (!(bv[u] && ix[u] == k) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("beat_timeout", u, 0, 1);
  endtask

  task automatic run(input int u, input int len);
    clr(u);
    send(u, len);
    wait_idle(u);
  endtask

  // second command held high while the first is still in flight
  task automatic b2b(input int u, input int gap);
    int n = 0;
    clr(u);
    send(u, 1);
    cv[u] = 1'b1;
    cl[u] = '0;
    @(negedge clk);
    while (!crdy[u] && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("b2b_gap", u, acc_cyc - done_cyc, gap);
    @(posedge clk);
    #1;
    cv[u] = 1'b0;
    wait_idle(u);
    chk("b2b_req_lat", u, rise_cyc - acc_cyc, 1);
    chk("b2b_done", u, done_cnt, 2);
    chk("b2b_beats", u, acc_cnt, 3);
  endtask

  initial begin
    cv[0] = 0; cv[1] = 0; cl[0] = '0; cl[1] = '0;
    tr[0] = 1; tr[1] = 1;
    clr(0);
    #1 rst_n = 1'b0;
    #2;
    for (int u = 0; u < 2; u++) begin
      chk("rst_cmd_ready", u, crdy[u], 1);
      chk("rst_req", u, rq[u], 0);
      chk("rst_beat_valid", u, bv[u], 0);
      chk("rst_done", u, dn[u], 0);
      chk("rst_dly", u, dl[u], 0);
      chk("rst_busy", u, bs[u], 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run(0, 3);
    chk("t1_beats", 0, acc_cnt, 4);
    chk("t1_valid_cyc", 0, bv_cnt, 4);
    chk("t1_idx_last", 0, idx_last, 3);
    chk("t1_done", 0, done_cnt, 1);
    chk("t1_dly_cyc", 0, dly_cnt, 2);
    chk("t1_req_lat", 0, rise_cyc - acc_cyc, 1);
    chk("t1_done_lat", 0, done_cyc - last_cyc, 1);

    clr(0);
    send(0, 3);
    wait_beat(0, 0);
    @(posedge clk);
    #1 tr[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 tr[0] = 1'b1;
    wait_idle(0);
    chk("t2_beats", 0, acc_cnt, 4);
    chk("t2_hold1", 0, hold1_cnt, 4);
    chk("t2_valid_cyc", 0, bv_cnt, 7);
    chk("t2_done", 0, done_cnt, 1);

    run(1, 2);
    chk("t3_beats", 1, acc_cnt, 3);
    chk("t3_done", 1, done_cnt, 1);
    chk("t3_dly_cyc", 1, dly_cnt, 0);

    b2b(0, 2);
    b2b(1, 1);

    run(0, 0);
    chk("t4_one_beat", 0, acc_cnt, 1);
    chk("t4_one_valid", 0, bv_cnt, 1);
    run(0, 15);
    chk("t4_16_beats", 0, acc_cnt, 16);
    chk("t4_16_last", 0, idx_last, 15);
    chk("t4_16_max", 0, idx_max, 15);

    clr(1);
    send(1, 3);
    wait_beat(1, 1);
    @(posedge clk);
    #1 gdrop[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 gdrop[1] = 1'b0;
    wait_idle(1);
    chk("t5_beats", 1, acc_cnt, 4);
    chk("t5_done", 1, done_cnt, 1);

    clr(0);
    send(0, 7);
    wait_beat(0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cmd_ready", 0, crdy[0], 1);
    chk("t6_req", 0, rq[0], 0);
    chk("t6_beat_valid", 0, bv[0], 0);
    chk("t6_beat_idx", 0, ix[0], 0);
    chk("t6_done", 0, dn[0], 0);
    chk("t6_dly", 0, dl[0], 0);
    chk("t6_busy", 0, bs[0], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_ready_after", 0, crdy[0], 1);
    chk("t6_no_done", 0, done_cnt, 0);
    run(0, 1);
    chk("t6_beats_after", 0, acc_cnt, 2);

`ifdef BUS_XFER_MASTER_WDOG_EN
    tr[0] = 1'b0;
    clr(0);
    send(0, 3);
    wait_idle(0);
    tr[0] = 1'b1;
    chk("wd_done", 0, done_cnt, 1);
    chk("wd_beats", 0, acc_cnt, 0);
    chk("wd_stall_cyc", 0, bv_cnt, 16);
    chk("wd_done_cyc", 0, done_cyc - first_bv, 16);
    chk("wd_err", 0, err_done, 1);
    send(0, 0);
    @(negedge clk);
    chk("wd_err_clear", 0, er[0], 0);
    wait_idle(0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_xfer_master.md
Name: bus_xfer_master

Overview:
- Requester-side stage that sits directly upstream of the bus arbiter FSM and drives its req/done/dly inputs.
- Consumes the arbiter's gnt output.
- Accepts one burst command at a time, raises req, and once granted issues cmd_len+1 beats to the target under a valid/ready handshake.
- Signals completion with done, and holds dly for a programmable bus turnaround so the arbiter parks in its wait state before freeing the bus.

Parameters:
- LEN_W, 4, width of the burst-length field (max burst 2^LEN_W beats).
- TURN_CYC, 2, turnaround cycles with dly high after the last beat. 0 = no turnaround.
- TO_CYC, 16, stall watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_len  in  LEN_W  beats minus one.
- req  out  1  bus request to the arbiter.
- gnt  in  1  bus grant from the arbiter.
- beat_valid  out  1  beat presented to the target.
- tgt_rdy  in  1  target accepts the beat.
- beat_idx  out  LEN_W  index of the current beat, 0-based.
- done  out  1  one-cycle completion pulse to the arbiter.
- dly  out  1  turnaround-in-progress to the arbiter.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state = IDLE, all counters = 0, every output 0 except cmd_ready = 1.
- All outputs are decoded from registered state and counters only; no combinational path from inputs to outputs except beat_valid (gated by gnt).
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_len into rem, clear beat_idx, go to REQ.
- REQ:
  - req = 1.
  - gnt = 1 → XFER. Wait indefinitely otherwise.
- XFER:
  - req = 1; beat_valid = gnt.
  - Beat accepted when beat_valid & tgt_rdy: beat_idx increments.
  - If beat_idx == rem at acceptance → CMPL.
  - A gnt drop mid-burst stalls the burst without losing beats.
- CMPL (exactly 1 cycle):
  - done = 1, dly = (TURN_CYC != 0), req = 0, beat_valid = 0.
  - If TURN_CYC > 1 → TURN with turn counter = TURN_CYC-1. Otherwise → IDLE.
- TURN:
  - dly = 1; decrement the turn counter; at 1 → IDLE.
- Net dly high time is exactly TURN_CYC cycles, starting in the done cycle. The arbiter therefore goes BUSY→WAIT→FREE when TURN_CYC > 0, and BUSY→FREE when TURN_CYC = 0.
- Latency:
  - cmd accept → req high: 1 cycle.
  - Last beat → done: 1 cycle.
  - Back-to-back command: accepted in the IDLE cycle following TURN/CMPL, req again on the next cycle.
- cmd_len = 0 is a single beat; cmd_len = all-ones is 2^LEN_W beats. beat_idx never wraps within a burst.
- cmd_valid outside IDLE is ignored (cmd_ready = 0); the command is held by the upstream source.
- Reset asserted mid-burst aborts immediately; no done is issued.

Optional Feature:
- Macro BUS_XFER_MASTER_WDOG_EN.
- When defined:
  - Adds output err (1 bit, reset 0) and a stall counter.
  - The counter counts consecutive XFER cycles with beat_valid & !tgt_rdy and clears on any accepted beat.
  - On reaching TO_CYC: abort the burst, go to CMPL (done pulse and normal turnaround), and set err = 1.
  - err clears on the next accepted command.
- When not defined: no err port, no counter, and XFER waits forever.

Decomposition:
- Shared package bus_xfer_pkg holds:
  - the state encoding (IDLE, REQ, XFER, CMPL, TURN; 3 bits);
  - default LEN_W/TURN_CYC/TO_CYC constants;
  - a function computing the turn counter width.
- One natural sub-module: bus_turn_timer, a loadable down-counter that produces dly and is reused by other bus masters.
- The watchdog stays inline.

Test Plan:
- cmd_len = 3, TURN_CYC = 2, gnt 1 cycle after req, tgt_rdy always 1 → exactly 4 beat_valid cycles with beat_idx 0..3; done pulses once in the following cycle; dly high for 2 cycles; then IDLE.
- Same, with tgt_rdy low on beat 1 for 3 cycles → beat_idx holds at 1 and beat_valid stays high; the burst completes with 4 accepted beats.
- TURN_CYC = 0 → done = 1 with dly = 0. The paired arbiter model goes BUSY→FREE and the next command gets req 1 cycle after acceptance.
- cmd_len = 0 and cmd_len = 15 (LEN_W = 4) → 1 and 16 beats respectively; no beat_idx wrap.
- Assert rst_n low during beat 2 of an 8-beat burst → all outputs at reset values asynchronously; no done; cmd_ready = 1 after release.
- BUS_XFER_MASTER_WDOG_EN, TO_CYC = 16, tgt_rdy stuck low → done in cycle 17 of the stall with err = 1; err clears on the next cmd accept.
